// File: rtl/hps_spim_resp_pkg.sv
// Shared types and frame-format constants for the HPS SPI-master responder.
package hps_spim_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned RW_BIT     = 7;
  localparam int unsigned ADDR_W     = 7;

endpackage

// File: rtl/hps_spim_resp_sync.sv
// N-stage synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level.
module hps_spim_resp_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sr_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sr_q   <= {sr_q[STAGES-2:0], d_i};
      prev_q <= sr_q[STAGES-1];
    end
  end

  assign q_o    = sr_q[STAGES-1];
  assign rise_o = sr_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sr_q[STAGES-1] & prev_q;

endmodule

// File: rtl/hps_spim_responder.sv
// SPI mode-0 slave answering 16-bit {rw, addr[6:0], data[7:0]} frames with a
// byte-wide register file, write/read strobes and an aborted-frame counter.
module hps_spim_responder
  import hps_spim_resp_pkg::*;
#(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  REG_RST     = 8'h00
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               spi_sclk,
  input  logic               spi_ss_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  output logic [NREGS*8-1:0] reg_q,
  output logic               wr_strobe,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  output logic               rd_strobe,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall, mosi_s;
  logic unused_sclk_lvl, unused_mosi_rise, unused_mosi_fall;

  hps_spim_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_clk), .rst_i(reset_reset), .d_i(spi_sclk),
    .q_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  hps_spim_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i(clk_clk), .rst_i(reset_reset), .d_i(spi_ss_n),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  hps_spim_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_clk), .rst_i(reset_reset), .d_i(spi_mosi),
    .q_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        cmd_sr_q, rx_sr_q, tx_sr_q;
  logic              miso_q, wr_strobe_q, rd_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q, err_cnt_q;
  logic [7:0]        regs_q [NREGS];
  logic [1:0]        arm_cnt_q;
  logic              armed_q;

  logic [7:0] cmd_next, rx_next, rd_byte;
  logic       wr_hit, abort, commit_wr;

  always_comb begin
    cmd_next = {cmd_sr_q[6:0], mosi_s};
    rx_next  = {rx_sr_q[6:0], mosi_s};
    rd_byte  = '0;
    wr_hit   = 1'b0;
    for (int unsigned n = 0; n < NREGS; n++) begin
      if (cmd_next[RW_BIT] && cmd_next[ADDR_W-1:0] == 7'(n)) rd_byte = regs_q[n];
      if (cmd_sr_q[ADDR_W-1:0] == 7'(n)) wr_hit = 1'b1;
    end
    abort     = ss_rise && (state_q == ST_CMD || state_q == ST_DATA);
    commit_wr = !abort && state_q == ST_DATA && sclk_rise &&
                bit_cnt_q == 4'(FRAME_BITS - 1) && !cmd_sr_q[RW_BIT] && wr_hit;
  end

  // The ss_n synchronizer resets to 1, so a low pin at reset release would look
  // like a falling edge; frames are only accepted once a genuine high was seen.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else if (arm_cnt_q != 2'(SYNC_STAGES)) begin
      arm_cnt_q <= arm_cnt_q + 2'd1;
    end else if (ss_s) begin
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_cnt_q   <= '0;
      for (int unsigned n = 0; n < NREGS; n++) regs_q[n] <= REG_RST;
    end else begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      for (int unsigned n = 0; n < NREGS; n++)
        if (commit_wr && cmd_sr_q[ADDR_W-1:0] == 7'(n)) regs_q[n] <= rx_next;

      if (abort) begin
        state_q <= ST_IDLE;
        miso_q  <= 1'b0;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
            if (armed_q && ss_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              cmd_sr_q  <= cmd_next;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(CMD_BITS - 1)) begin
                tx_sr_q <= rd_byte;
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              miso_q  <= tx_sr_q[7];
              tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_sr_q   <= rx_next;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                state_q <= ST_DONE;
                miso_q  <= 1'b0;
                if (cmd_sr_q[RW_BIT]) begin
                  rd_strobe_q <= 1'b1;
                end else if (wr_hit) begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= cmd_sr_q[ADDR_W-1:0];
                  wr_data_q   <= rx_next;
                end
              end
            end
          end
          ST_DONE: begin
            miso_q <= 1'b0;
            if (ss_rise) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned n = 0; n < NREGS; n++) reg_q[8*n +: 8] = regs_q[n];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~ss_s;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_strobe   = rd_strobe_q;
  assign busy        = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_hps_spim_responder.sv
// Scoreboard bench for hps_spim_responder driven by a mode-0 SPI master model
// with SCLK at one tenth of clk_clk.
module tb_hps_spim_responder;

  localparam int unsigned NREGS = 16;

  logic               clk_clk = 1'b0;
  logic               reset_reset = 1'b1;
  logic               spi_sclk = 1'b0;
  logic               spi_ss_n = 1'b1;
  logic               spi_mosi = 1'b0;
  logic               spi_miso, spi_miso_oe;
  logic [NREGS*8-1:0] reg_q;
  logic               wr_strobe, rd_strobe, busy;
  logic [6:0]         wr_addr;
  logic [7:0]         wr_data, err_cnt;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [14:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  last_miso = '0;

  always #5 clk_clk = ~clk_clk;

  hps_spim_responder #(.NREGS(NREGS), .SYNC_STAGES(2), .REG_RST(8'h00)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .reg_q(reg_q),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .busy(busy), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Mode 0 master: MOSI changes with SCLK low, MISO sampled just before each rise.
  task automatic spi_xfer(input logic [15:0] frame, input int unsigned nbits,
                          input bit end_ss, input int unsigned extra);
    logic [15:0] rx;
    rx = '0;
    spi_ss_n = 1'b0;
    #100;
    for (int unsigned i = 0; i < nbits; i++) begin
      spi_mosi = frame[15-i];
      #50;
      rx[15-i] = spi_miso;
      if (i == 15) last_miso = rx[7:0];
      spi_sclk = 1'b1;
      #50;
      spi_sclk = 1'b0;
    end
    for (int unsigned i = 0; i < extra; i++) begin
      spi_mosi = ~spi_mosi;
      #50 spi_sclk = 1'b1;
      #50 spi_sclk = 1'b0;
    end
    if (end_ss) begin
      #50;
      spi_ss_n = 1'b1;
      spi_mosi = 1'b0;
      #100;
    end
  endtask

  initial begin : wr_monitor
    logic [14:0] e;
    forever begin
      @(negedge clk_clk);
      if (wr_strobe) begin
        chk("wr_strobe_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'(e));
        end
      end
    end
  end

  initial begin : rd_monitor
    logic [7:0] e;
    forever begin
      @(negedge clk_clk);
      if (rd_strobe) begin
        chk("rd_strobe_expected", 64'(exp_rd.size() > 0), 64'd1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          chk("rd_miso_byte", 64'(last_miso), 64'(e));
        end
      end
    end
  end

  initial begin : stim
    repeat (5) @(negedge clk_clk);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    chk("rst_regs_lo", reg_q[63:0], 64'd0);
    chk("rst_regs_hi", reg_q[127:64], 64'd0);
    chk("rst_outputs", 64'({spi_miso, spi_miso_oe, wr_strobe, rd_strobe, busy}), 64'd0);
    chk("rst_wr_fields", 64'({wr_addr, wr_data, err_cnt}), 64'd0);
    repeat (5) @(negedge clk_clk);

    // write 0x03 <- A5, then read it back
    exp_wr.push_back({7'h03, 8'hA5});
    spi_xfer(16'h03A5, 16, 1'b1, 0);
    @(negedge clk_clk);
    chk("reg3_after_write", 64'(reg_q[31:24]), 64'hA5);
    exp_rd.push_back(8'hA5);
    spi_xfer(16'h8300, 16, 1'b1, 0);
    @(negedge clk_clk);
    chk("reg3_after_read", 64'(reg_q[31:24]), 64'hA5);

    // unmapped read and unmapped write
    exp_rd.push_back(8'h00);
    spi_xfer(16'hFF00, 16, 1'b1, 0);
    spi_xfer(16'h4077, 16, 1'b1, 0);
    @(negedge clk_clk);
    chk("err_after_unmapped", 64'(err_cnt), 64'd0);

    // abort after 11 bits
    spi_xfer(16'h053C, 11, 1'b1, 0);
    @(negedge clk_clk);
    chk("reg5_after_abort", 64'(reg_q[47:40]), 64'h00);
    chk("err_after_abort", 64'(err_cnt), 64'd1);

    // reset during bit 12 with ss_n held low through release
    spi_xfer(16'h0799, 12, 1'b0, 0);
    @(negedge clk_clk);
    chk("busy_mid_frame", 64'(busy), 64'd1);
    chk("miso_oe_mid_frame", 64'(spi_miso_oe), 64'd1);
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    repeat (10) @(negedge clk_clk);
    chk("regs_lo_after_reset", reg_q[63:0], 64'd0);
    chk("regs_hi_after_reset", reg_q[127:64], 64'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      spi_mosi = ~spi_mosi;
      #50 spi_sclk = 1'b1;
      #50 spi_sclk = 1'b0;
    end
    @(negedge clk_clk);
    chk("idle_while_ss_low", 64'(busy), 64'd0);
    #50 spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    #100;
    @(negedge clk_clk);
    chk("err_after_reset", 64'(err_cnt), 64'd0);
    exp_wr.push_back({7'h0A, 8'h5A});
    spi_xfer(16'h0A5A, 16, 1'b1, 0);
    @(negedge clk_clk);
    chk("reg10_after_reset_frame", 64'(reg_q[87:80]), 64'h5A);

    // back-to-back writes, extra SCLKs after bit 16
    exp_wr.push_back({7'h00, 8'h11});
    spi_xfer(16'h0011, 16, 1'b1, 0);
    exp_wr.push_back({7'h01, 8'h22});
    spi_xfer(16'h0122, 16, 1'b1, 4);
    @(negedge clk_clk);
    chk("reg0_b2b", 64'(reg_q[7:0]), 64'h11);
    chk("reg1_b2b", 64'(reg_q[15:8]), 64'h22);
    chk("reg2_untouched", 64'(reg_q[23:16]), 64'h00);
    chk("err_after_b2b", 64'(err_cnt), 64'd0);

    // saturation of the aborted-frame counter
    for (int unsigned i = 0; i < 255; i++) spi_xfer(16'hFFFF, 1, 1'b1, 0);
    @(negedge clk_clk);
    chk("err_at_255", 64'(err_cnt), 64'd255);
    for (int unsigned i = 0; i < 45; i++) spi_xfer(16'h0000, 1, 1'b1, 0);
    @(negedge clk_clk);
    chk("err_saturated", 64'(err_cnt), 64'd255);

    repeat (20) @(negedge clk_clk);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
